// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with two combinational read
// ports and one synchronous write port. An optional hardwired zero register
// and an optional same-cycle write-to-read bypass are available. Storage is
// cleared asynchronously by the active-low reset.
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    // DEPTH as an ADDR_W+1 bit value, so range checks compare equal widths
    // even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_legal;
    logic             rd1_legal;
    logic             rd2_legal;

    // A write is legal only out of reset, in range, and not aimed at a
    // hardwired zero register. Illegal writes are never bypassed either.
    always_comb begin
        wr_legal = 1'b0;
        if (reset && we && ({1'b0, waddr} < DEPTH_L)) begin
            if (!(ZERO_REG && (waddr == '0))) begin
                wr_legal = 1'b1;
            end
        end
    end

    // Next-state of the storage array: hold everything, update one word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_legal) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage array; reset clears every word without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read address qualification, one per port: out of reset, in range,
    // and not the hardwired zero register.
    always_comb begin
        rd1_legal = reset && ({1'b0, raddr1} < DEPTH_L)
                    && !(ZERO_REG && (raddr1 == '0));
        rd2_legal = reset && ({1'b0, raddr2} < DEPTH_L)
                    && !(ZERO_REG && (raddr2 == '0));
    end

    // Read port 1: zero unless qualified; forward the write data when the
    // bypass is enabled and a legal write targets the same address.
    always_comb begin
        rdata1 = '0;
        if (rd1_legal) begin
            if (BYPASS && wr_legal && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem_q[raddr1];
            end
        end
    end

    // Read port 2: same rules as port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        if (rd2_legal) begin
            if (BYPASS && wr_legal && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem_q[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w. Three instances share the same stimulus:
//   dut_a: defaults (DEPTH 32, zero register, bypass)
//   dut_b: DEPTH 32, no zero register, no bypass
//   dut_c: DEPTH 24, zero register, bypass
// Directed vectors with hand-computed values, then a random soak checked
// against a small behavioural model with periodic reset pulses.
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;

    int checks;
    int errors;

    // Behavioural model: one 32-entry array per instance plus its config.
    logic [31:0] m [3][32];
    int          cfg_depth [3] = '{32, 32, 24};
    bit          cfg_zr    [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_a), .raddr2(raddr2), .rdata2(rd2_a));

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b));

    regfile_2r1w #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_c), .raddr2(raddr2), .rdata2(rd2_c));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_wr_legal(input int k);
        return reset && we && (int'(waddr) < cfg_depth[k]) && !(cfg_zr[k] && waddr == 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [4:0] ra);
        if (!reset) return 32'h0;
        if (int'(ra) >= cfg_depth[k]) return 32'h0;
        if (cfg_zr[k] && ra == 5'd0) return 32'h0;
        if (cfg_byp[k] && model_wr_legal(k) && waddr == ra) return wdata;
        return m[k][ra];
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
        end
    endtask

    // Commit the pending write to the model, then advance one clock edge.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            if (model_wr_legal(k)) m[k][waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a1"}, rd1_a, model_read(0, raddr1));
        check({tag, "_a2"}, rd2_a, model_read(0, raddr2));
        check({tag, "_b1"}, rd1_b, model_read(1, raddr1));
        check({tag, "_b2"}, rd2_b, model_read(1, raddr2));
        check({tag, "_c1"}, rd1_c, model_read(2, raddr1));
        check({tag, "_c2"}, rd2_c, model_read(2, raddr2));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        set_reset(1'b0);

        // Reset state: all reads zero, even with a bypass-shaped write pending.
        drive(1'b1, 5'd4, 32'h5555_AAAA, 5'd4, 5'd31);
        check("rst_a1", rd1_a, 32'h0);
        check("rst_a2", rd2_a, 32'h0);
        check("rst_b1", rd1_b, 32'h0);
        check("rst_c1", rd1_c, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        set_reset(1'b1);
        #1;
        check("rst_blk_a", rd1_a, 32'h0);
        check("rst_blk_b", rd1_b, 32'h0);

        // Basic write/read.
        drive(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
        check("basic_a1", rd1_a, 32'h1234_5678);
        check("basic_a2", rd2_a, 32'hCAFE_F00D);
        check("basic_b1", rd1_b, 32'h1234_5678);
        check("basic_b2", rd2_b, 32'hCAFE_F00D);
        check("basic_c1", rd1_c, 32'h1234_5678);
        check("basic_c2", rd2_c, 32'hCAFE_F00D);

        // Zero register: illegal write is neither stored nor bypassed.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("zr_wc_a1", rd1_a, 32'h0);
        check("zr_wc_a2", rd2_a, 32'h0);
        check("zr_wc_b1", rd1_b, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("zr_a1", rd1_a, 32'h0);
        check("zr_a2", rd2_a, 32'h0);
        check("zr_b1", rd1_b, 32'hFFFF_FFFF);
        check("zr_b2", rd2_b, 32'hFFFF_FFFF);

        // Bypass vs. no bypass.
        drive(1'b1, 5'd3, 32'h0000_0011, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd3, 32'h0000_0022, 5'd3, 5'd3);
        check("byp_a1", rd1_a, 32'h0000_0022);
        check("byp_a2", rd2_a, 32'h0000_0022);
        check("byp_b1", rd1_b, 32'h0000_0011);
        check("byp_b2", rd2_b, 32'h0000_0011);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        check("byp_post_b1", rd1_b, 32'h0000_0022);
        check("byp_post_b2", rd2_b, 32'h0000_0022);
        check("byp_post_a1", rd1_a, 32'h0000_0022);

        // Out of range on the DEPTH=24 instance; no aliasing onto r6.
        drive(1'b1, 5'd6, 32'h0000_0066, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd30, 32'h0000_00AA, 5'd30, 5'd6);
        check("oor_wc_c1", rd1_c, 32'h0);
        check("oor_wc_a1", rd1_a, 32'h0000_00AA);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd30, 5'd6);
        check("oor_c1", rd1_c, 32'h0);
        check("oor_c2", rd2_c, 32'h0000_0066);
        check("oor_a1", rd1_a, 32'h0000_00AA);

        // Reset between edges clears storage at once; write during reset is lost.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        check("mid_pre_a1", rd1_a, 32'hDEAD_BEEF);
        #2;
        set_reset(1'b0);
        #1;
        check("mid_a1", rd1_a, 32'h0);
        check("mid_b1", rd1_b, 32'h0);
        check("mid_c1", rd1_c, 32'h0);
        check("mid_a2", rd2_a, 32'h0);
        drive(1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd5);
        check("mid_wr_a1", rd1_a, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        set_reset(1'b1);
        #1;
        check("mid_lost_a1", rd1_a, 32'h0);
        check("mid_lost_b1", rd1_b, 32'h0);
        check("mid_lost_a2", rd2_a, 32'h0);

        // Random soak against the model, reset pulsed every 200 cycles.
        for (int i = 0; i < 1000; i++) begin
            if (i % 200 == 150) set_reset(1'b0);
            else if (!reset) set_reset(1'b1);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (i % 7 == 0) raddr2 = waddr;
            if (i % 11 == 0) raddr1 = waddr;
            #1;
            check_model("soak");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
